cpu_run_ctrl: RTL
=================

# cpu_run_ctrl

Run controller for the FRANK6000 CPU core. It receives a program as a byte stream over a valid/ready handshake, assembles 16-bit instructions, and writes them into the CPU instruction memory. It then pulses the CPU reset and generates the periodic `control_en` strobe. When the CPU raises `loopf` (end-of-program idle loop) or a step budget runs out, it stops the CPU and latches `WREG` as the result.

## Interface
- `DIV`, default 4: `o_control_en` period in clocks; legal values 2..16.
- `MAX_STEPS`, default 4096: `control_en` strobes allowed before timeout; legal values 1..65535.
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  start pulse; begins a load session.
- `i_abort`  in  1  forces return to IDLE from any state.
- `i_len`  in  8  instruction count minus 1 (1..256 words); sampled on accepted `i_start`.
- `i_byte`  in  8  program byte; high byte of each word first.
- `i_byte_valid`  in  1  byte present.
- `o_byte_ready`  out  1  controller accepts a byte this cycle.
- `o_instr_addr`  out  8  instruction memory write address.
- `o_instr`  out  16  instruction memory write data.
- `o_instr_we`  out  1  instruction memory write enable.
- `o_cpu_rst`  out  1  CPU reset, active-high.
- `o_ON`  out  1  CPU run enable.
- `o_control_en`  out  1  CPU step strobe.
- `i_loopf`  in  1  CPU loop flag.
- `i_WREG`  in  8  CPU working register.
- `o_result`  out  8  `WREG` captured at completion.
- `o_busy`  out  1  state is not IDLE and not DONE.
- `o_done`  out  1  run ended on `loopf`.
- `o_timeout`  out  1  run ended on step budget.

## Operation
- States: IDLE, LOAD_HI, LOAD_LO, WRITE, CPU_RST, RUN, DONE.
- IDLE, and DONE on `i_start`:
  - go to LOAD_HI;
  - addr=0;
  - latch `i_len`;
  - clear `o_done`, `o_timeout`, `o_result`.
- LOAD_HI: `o_byte_ready`=1. On accept, hold the byte as the high byte and go to LOAD_LO.
- LOAD_LO: `o_byte_ready`=1. On accept, form the word {hi,lo} and go to WRITE.
- WRITE: for exactly 1 cycle, `o_instr_we`=1, `o_instr_addr`=addr, `o_instr`=word, `o_byte_ready`=0.
  - If addr==len, go to CPU_RST.
  - Otherwise addr+1 (8-bit) and go to LOAD_HI.
  - addr never wraps: len=255 ends at addr 255.
- CPU_RST: `o_cpu_rst`=1 for exactly 2 cycles, `o_ON`=0, then go to RUN.
- RUN: `o_ON`=1. Divider starts at 0 on entry.
  - `o_control_en`=1 when divider==0; divider counts 0..DIV-1 and wraps.
  - The step counter (16-bit) increments on each strobe.
- Termination (checked in RUN, only after at least one strobe has been issued):
  - `i_loopf`=1: `o_result`←`i_WREG` in the same edge, `o_done`=1, go to DONE.
  - Otherwise, step count reaching MAX_STEPS while not done: `o_timeout`=1, `o_result`←`i_WREG`, go to DONE.
  - `loopf` and the final step together: `o_done` wins, `o_timeout` stays 0.
- DONE: `o_ON`=0, `o_control_en`=0. `o_result`, `o_done` and `o_timeout` hold until the next accepted `i_start`.
- `i_abort`:
  - from any state, go to IDLE next cycle;
  - `o_ON`, `o_instr_we`, `o_cpu_rst` and `o_byte_ready` deassert at that edge;
  - `o_done`=0, `o_timeout`=0.
  - A partially assembled word is discarded; words already written stay in memory.
  - `i_abort` has priority over `i_start` in the same cycle.
- `i_start` is ignored in LOAD_*, WRITE, CPU_RST and RUN.

## Timing
- All outputs are registered.
- Reset values: every output 0, state IDLE, counters 0.
- Reset asserted mid-run: all outputs clear asynchronously, including `o_ON` and `o_instr_we`.
- Byte accept: `i_byte_valid` && `o_byte_ready` at a rising edge. `o_byte_ready` does not depend combinationally on `i_byte_valid`.
- Load throughput: at most 1 word per 3 cycles (LOAD_HI, LOAD_LO, WRITE). Back-to-back valid bytes give exactly 3 cycles per word.
- Write timing: `o_instr_we` rises the cycle after the low byte is accepted.
- Load-to-run latency: after the last WRITE cycle, 2 `o_cpu_rst` cycles, then the first RUN cycle carries `o_control_en`=1.
- Strobe period: exactly DIV cycles, each strobe 1 cycle wide.
- Completion: DONE and `o_done` are visible 1 cycle after `i_loopf` is sampled high in RUN. `o_ON` falls at the same edge.

## Test plan
- Load 2 words 0x1234, 0xABCD (`i_len`=1, valid held high).
  - Required: writes (0,0x1234) and (1,0xABCD), 3 cycles apart, each `o_instr_we` 1 cycle.
  - Then `o_cpu_rst` high 2 cycles, then `o_control_en` pulses every 4 cycles.
- Load 1 word, then raise `i_loopf` with `i_WREG`=0x2A after 5 strobes.
  - Required: `o_result`=0x2A, `o_done`=1, `o_ON`=0 the next cycle; no further strobes.
- MAX_STEPS=8 with `i_loopf` held 0.
  - Required: exactly 8 strobes, then `o_timeout`=1, `o_done`=0, `o_result`=`i_WREG`.
- Gapped source: `i_byte_valid` toggling every other cycle.
  - Required: data stays correct and no byte is lost or duplicated.
  - `i_len`=255 loads addresses 0..255 with no wrap.
- `i_abort` during LOAD_LO, and separately during RUN.
  - Required: IDLE next cycle, `o_ON`=0, no spurious `o_instr_we`.
  - `i_start`+`i_abort` in the same cycle: stays IDLE.
- `i_rst` low mid-RUN.
  - Required: all outputs 0 asynchronously; after release, `i_start` begins a clean load at addr 0.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cpu_run_ctrl
//
// Run controller for the FRANK6000 CPU core. It takes a program as a stream of
// bytes (high byte of each word first), assembles 16-bit instructions and
// writes them into the CPU instruction memory. It then holds the CPU in reset
// for two cycles and lets it run, issuing one control_en strobe every DIV
// clocks. The run ends when the CPU raises loopf (done) or when MAX_STEPS
// strobes have been issued (timeout). In both cases WREG is captured as the
// result.
//
// Parameters
//   DIV        control_en period in clocks (2..16)
//   MAX_STEPS  strobes allowed before timeout (1..65535)
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-low reset
//   i_start, i_abort      start a load session / force return to IDLE
//   i_len                 instruction count minus 1, sampled on start
//   i_byte, i_byte_valid  program byte stream
//   o_byte_ready          a byte is accepted this cycle if valid
//   o_instr_addr/o_instr/o_instr_we   instruction memory write port
//   o_cpu_rst, o_ON, o_control_en     CPU reset, run enable, step strobe
//   i_loopf, i_WREG       CPU idle-loop flag and working register
//   o_result              WREG captured at completion
//   o_busy, o_done, o_timeout         status
//
// Every output is a flop; the next value of each is derived from the next
// state so outputs line up with the state they belong to.
// -----------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter int DIV       = 4,
  parameter int MAX_STEPS = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [7:0]  i_len,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic [7:0]  o_instr_addr,
  output logic [15:0] o_instr,
  output logic        o_instr_we,
  output logic        o_cpu_rst,
  output logic        o_ON,
  output logic        o_control_en,
  input  logic        i_loopf,
  input  logic [7:0]  i_WREG,
  output logic [7:0]  o_result,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_timeout
);

  localparam logic [3:0]  DIV_LAST   = 4'(DIV - 1);
  localparam logic [15:0] STEP_LIMIT = 16'(MAX_STEPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_HI,
    S_LOAD_LO,
    S_WRITE,
    S_CPU_RST,
    S_RUN,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] word_q, word_d;
  logic [7:0]  result_q, result_d;
  logic [15:0] steps_q, steps_d;
  logic [3:0]  div_q, div_d;
  logic [3:0]  div_next;
  logic        rst_cnt_q, rst_cnt_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        on_q, on_d;
  logic        strobe_q, strobe_d;
  logic        busy_q, busy_d;
  logic        accept;

  // ready is a flop, so acceptance never loops back through i_byte_valid
  assign accept   = i_byte_valid & ready_q;
  assign div_next = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    hi_d      = hi_q;
    word_d    = word_q;
    result_d  = result_q;
    steps_d   = steps_q;
    div_d     = div_q;
    rst_cnt_d = rst_cnt_q;
    done_d    = done_q;
    timeout_d = timeout_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d   = S_LOAD_HI;
          addr_d    = 8'd0;
          len_d     = i_len;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          result_d  = 8'd0;
        end
      end
      S_LOAD_HI: begin
        if (accept) begin
          hi_d    = i_byte;
          state_d = S_LOAD_LO;
        end
      end
      S_LOAD_LO: begin
        if (accept) begin
          word_d  = {hi_q, i_byte};
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // compare before increment so len=255 stops at 255 without wrapping
        if (addr_q == len_q) begin
          state_d   = S_CPU_RST;
          rst_cnt_d = 1'b0;
        end else begin
          addr_d  = addr_q + 8'd1;
          state_d = S_LOAD_HI;
        end
      end
      S_CPU_RST: begin
        if (rst_cnt_q) begin
          // first RUN cycle carries a strobe, which counts as step 1
          state_d = S_RUN;
          div_d   = 4'd0;
          steps_d = 16'd1;
        end else begin
          rst_cnt_d = 1'b1;
        end
      end
      S_RUN: begin
        // steps_q >= 1 throughout RUN, so termination always follows a strobe;
        // loopf is tested first so it wins over a coincident final step
        if (i_loopf) begin
          result_d = i_WREG;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else if (steps_q == STEP_LIMIT) begin
          result_d  = i_WREG;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          div_d = div_next;
          if (div_next == 4'd0) begin
            steps_d = steps_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // abort overrides everything, including a same-cycle start
    if (i_abort) begin
      state_d   = S_IDLE;
      done_d    = 1'b0;
      timeout_d = 1'b0;
    end

    ready_d   = (state_d == S_LOAD_HI) || (state_d == S_LOAD_LO);
    we_d      = (state_d == S_WRITE);
    cpu_rst_d = (state_d == S_CPU_RST);
    on_d      = (state_d == S_RUN);
    strobe_d  = on_d && (div_d == 4'd0);
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      addr_q    <= 8'd0;
      len_q     <= 8'd0;
      hi_q      <= 8'd0;
      word_q    <= 16'd0;
      result_q  <= 8'd0;
      steps_q   <= 16'd0;
      div_q     <= 4'd0;
      rst_cnt_q <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      cpu_rst_q <= 1'b0;
      on_q      <= 1'b0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      hi_q      <= hi_d;
      word_q    <= word_d;
      result_q  <= result_d;
      steps_q   <= steps_d;
      div_q     <= div_d;
      rst_cnt_q <= rst_cnt_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      cpu_rst_q <= cpu_rst_d;
      on_q      <= on_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
    end
  end

  assign o_byte_ready = ready_q;
  assign o_instr_addr = addr_q;
  assign o_instr      = word_q;
  assign o_instr_we   = we_q;
  assign o_cpu_rst    = cpu_rst_q;
  assign o_ON         = on_q;
  assign o_control_en = strobe_q;
  assign o_result     = result_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_timeout    = timeout_q;

endmodule
